// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator processor: opcodes (common to ALU and
// controller), controller state encoding and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_LDA  = 4'b0100;
    localparam logic [3:0] OP_STA  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_JZ   = 4'b0111;
    localparam logic [3:0] OP_JC   = 4'b1000;
    localparam logic [3:0] OP_SHFR = 4'b1011;
    localparam logic [3:0] OP_SHFL = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int OPC_MSB   = 7;
    localparam int OPC_LSB   = 4;
    localparam int RADDR_MSB = 3;
    localparam int RADDR_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_JUMP,
        ST_HALT
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_SHFR, OP_SHFL: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_jump_op(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter with load-over-increment priority; wraps modulo 2^PC_W.
module program_counter #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RST_PC;
        end else if (load) begin
            pc <= load_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/cpu_controller_fsm.sv
// Control unit for the 8-bit accumulator processor: fetch/decode/execute
// sequencing, ALU opcode drive, ACC/register-file strobes and branch flags.
//
// state  | meaning
// FETCH  | mem_addr = PC, mem_rd = 1
// DECODE | IR <= read data, PC <= PC+1
// EXEC   | ALU/LDA/STA strobes; jumps read operand byte at PC
// JUMP   | PC <= operand if taken, else PC+1
// HALT   | halted = 1, PC frozen, exit only by reset
module cpu_controller_fsm
    import cpu_pkg::*;
#(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      mem_data_in,
    input  logic            alu_zero_flag,
    input  logic            alu_carry_out,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_rd,
    output logic [3:0]      alu_select,
    output logic            acc_load,
    output logic            acc_src_sel,
    output logic            reg_load,
    output logic [3:0]      reg_addr,
    output logic            halted
);

    state_t          state;
    logic [7:0]      ir;
    logic            z_flag;
    logic            c_flag;
    logic            rd_q;
    logic [PC_W-1:0] pc;
    logic [3:0]      opcode;
    logic [3:0]      next_op;
    logic            jump_taken;
    logic            pc_inc;
    logic            pc_load;

    assign opcode  = ir[OPC_MSB:OPC_LSB];
    assign next_op = mem_data_in[OPC_MSB:OPC_LSB];

    assign jump_taken = (opcode == OP_JMP)
                     || ((opcode == OP_JZ) && z_flag)
                     || ((opcode == OP_JC) && c_flag);

    assign pc_inc  = (state == ST_DECODE) || ((state == ST_JUMP) && !jump_taken);
    assign pc_load = (state == ST_JUMP) && jump_taken;

    program_counter #(
        .PC_W   (PC_W),
        .RST_PC (RST_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (PC_W'(mem_data_in)),
        .pc       (pc)
    );

    assign mem_addr = pc;
    assign reg_addr = ir[RADDR_MSB:RADDR_LSB];
    // rd_q resets to its FETCH value so the first fetch happens on the first
    // edge after release; the gate keeps the strobe low while reset is held.
    assign mem_rd   = rd_q & rst_n;

    // Outputs are registered one state ahead so they are stable for the whole
    // of the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            ir          <= 8'h00;
            z_flag      <= 1'b0;
            c_flag      <= 1'b0;
            rd_q        <= 1'b1;
            alu_select  <= OP_NOP;
            acc_load    <= 1'b0;
            acc_src_sel <= 1'b0;
            reg_load    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            rd_q        <= 1'b0;
            alu_select  <= OP_NOP;
            acc_load    <= 1'b0;
            acc_src_sel <= 1'b0;
            reg_load    <= 1'b0;
            case (state)
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir    <= mem_data_in;
                    state <= ST_EXEC;
                    if (is_alu_op(next_op)) begin
                        alu_select <= next_op;
                        acc_load   <= 1'b1;
                    end else if (next_op == OP_LDA) begin
                        acc_load    <= 1'b1;
                        acc_src_sel <= 1'b1;
                    end else if (next_op == OP_STA) begin
                        reg_load <= 1'b1;
                    end else if (is_jump_op(next_op)) begin
                        rd_q <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (is_alu_op(opcode)) begin
                        z_flag <= alu_zero_flag;
                        c_flag <= alu_carry_out;
                    end
                    if (is_jump_op(opcode)) begin
                        state <= ST_JUMP;
                    end else if (opcode == OP_HALT) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                        rd_q  <= 1'b1;
                    end
                end
                ST_JUMP: begin
                    state <= ST_FETCH;
                    rd_q  <= 1'b1;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state  <= ST_FETCH;
                    rd_q   <= 1'b1;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller_fsm.sv
// Bench for cpu_controller_fsm: synchronous memory and flag-driving ALU model,
// per-cycle expected outputs queued per program and compared as the DUT runs.
module tb_cpu_controller_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mem_data_in;
    logic       alu_zero_flag;
    logic       alu_carry_out;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [3:0] alu_select;
    logic       acc_load;
    logic       acc_src_sel;
    logic       reg_load;
    logic [3:0] reg_addr;
    logic       halted;

    cpu_controller_fsm #(.PC_W(8), .RST_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_data_in   (mem_data_in),
        .alu_zero_flag (alu_zero_flag),
        .alu_carry_out (alu_carry_out),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .alu_select    (alu_select),
        .acc_load      (acc_load),
        .acc_src_sel   (acc_src_sel),
        .reg_load      (reg_load),
        .reg_addr      (reg_addr),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] mem_q;
    always @(posedge clk) if (mem_rd) mem_q <= mem[mem_addr];
    assign mem_data_in = mem_q;

    // Flags carry the programmed value only while an ALU op is selected and the
    // inverse otherwise, so sampling in the wrong cycle changes the result.
    logic zero_val = 1'b0;
    logic carry_val = 1'b0;
    assign alu_zero_flag = (alu_select != 4'b0000) ? zero_val : ~zero_val;
    assign alu_carry_out = (alu_select != 4'b0000) ? carry_val : ~carry_val;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h required %h", tag, obs, exp);
        end
    endtask

    // {ra, halted, reg_load, acc_src_sel, acc_load, alu_select, mem_rd, mem_addr}
    function automatic logic [31:0] pk(input logic [7:0] a, input logic rd, input logic [3:0] sel,
                                       input logic ld, input logic src, input logic rl,
                                       input logic h, input logic [3:0] ra);
        return {11'b0, ra, h, rl, src, ld, sel, rd, a};
    endfunction

    function automatic logic [31:0] obs_vec();
        return pk(mem_addr, mem_rd, alu_select, acc_load, acc_src_sel, reg_load, halted, reg_addr);
    endfunction

    task automatic push_exp(input logic [7:0] a, input logic rd, input logic [3:0] sel,
                            input logic ld, input logic src, input logic rl,
                            input logic h, input logic [3:0] ra);
        exp_q.push_back(pk(a, rd, sel, ld, src, rl, h, ra));
    endtask

    task automatic idle(input logic [7:0] a, input logic rd, input logic [3:0] ra);
        push_exp(a, rd, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, ra);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic start(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_val({name, "_reset"}, obs_vec(), pk(8'h00, 0, 4'h0, 0, 0, 0, 0, 4'h0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Ends one time unit after the negedge of the final expected cycle.
    task automatic run_trace(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            #1 check_val($sformatf("%s_c%0d", name, n + 1), obs_vec(), exp_q.pop_front());
            n++;
            if (exp_q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic async_reset_check(input string name);
        #2 rst_n = 1'b0;
        #1 check_val(name, obs_vec(), pk(8'h00, 0, 4'h0, 0, 0, 0, 0, 4'h0));
    endtask

    initial begin
        // ADD r1 then HALT, async reset out of HALT
        clear_mem(); mem[0] = 8'h11; mem[1] = 8'hF0;
        zero_val = 0; carry_val = 0;
        start("add");
        idle(8'h00, 1, 4'h0); idle(8'h00, 0, 4'h0);
        push_exp(8'h01, 0, 4'h1, 1, 0, 0, 0, 4'h1);
        idle(8'h01, 1, 4'h1); idle(8'h01, 0, 4'h1); idle(8'h02, 0, 4'h0);
        for (int i = 0; i < 20; i++) push_exp(8'h02, 0, 4'h0, 0, 0, 0, 1, 4'h0);
        run_trace("add_halt");
        async_reset_check("halt_async_reset");

        // SUB zero=1 then JZ 0x40 taken
        clear_mem(); mem[0] = 8'h22; mem[1] = 8'h70; mem[2] = 8'h40; mem[3] = 8'hF0; mem[8'h40] = 8'hF0;
        zero_val = 1; carry_val = 0;
        start("jz_t");
        idle(8'h00, 1, 4'h0); idle(8'h00, 0, 4'h0);
        push_exp(8'h01, 0, 4'h2, 1, 0, 0, 0, 4'h2);
        idle(8'h01, 1, 4'h2); idle(8'h01, 0, 4'h2);
        idle(8'h02, 1, 4'h0); idle(8'h02, 0, 4'h0);
        idle(8'h40, 1, 4'h0); idle(8'h40, 0, 4'h0); idle(8'h41, 0, 4'h0);
        push_exp(8'h41, 0, 4'h0, 0, 0, 0, 1, 4'h0);
        run_trace("jz_taken");

        // Same program, zero=0: operand skipped
        zero_val = 0;
        start("jz_n");
        idle(8'h00, 1, 4'h0); idle(8'h00, 0, 4'h0);
        push_exp(8'h01, 0, 4'h2, 1, 0, 0, 0, 4'h2);
        idle(8'h01, 1, 4'h2); idle(8'h01, 0, 4'h2);
        idle(8'h02, 1, 4'h0); idle(8'h02, 0, 4'h0);
        idle(8'h03, 1, 4'h0); idle(8'h03, 0, 4'h0); idle(8'h04, 0, 4'h0);
        push_exp(8'h04, 0, 4'h0, 0, 0, 0, 1, 4'h0);
        run_trace("jz_not_taken");

        // ADD carry=1, LDA r5, JC 0x20: carry held across LDA
        clear_mem(); mem[0] = 8'h13; mem[1] = 8'h45; mem[2] = 8'h80; mem[3] = 8'h20;
        mem[4] = 8'hF0; mem[8'h20] = 8'hF0;
        zero_val = 0; carry_val = 1;
        start("jc");
        idle(8'h00, 1, 4'h0); idle(8'h00, 0, 4'h0);
        push_exp(8'h01, 0, 4'h1, 1, 0, 0, 0, 4'h3);
        idle(8'h01, 1, 4'h3); idle(8'h01, 0, 4'h3);
        push_exp(8'h02, 0, 4'h0, 1, 1, 0, 0, 4'h5);
        idle(8'h02, 1, 4'h5); idle(8'h02, 0, 4'h5);
        idle(8'h03, 1, 4'h0); idle(8'h03, 0, 4'h0);
        idle(8'h20, 1, 4'h0); idle(8'h20, 0, 4'h0); idle(8'h21, 0, 4'h0);
        push_exp(8'h21, 0, 4'h0, 0, 0, 0, 1, 4'h0);
        run_trace("jc_taken");

        // JMP 0xFF, NOP at 0xFF wraps PC to 0x00
        clear_mem(); mem[0] = 8'h60; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
        zero_val = 0; carry_val = 0;
        start("wrap");
        idle(8'h00, 1, 4'h0); idle(8'h00, 0, 4'h0);
        idle(8'h01, 1, 4'h0); idle(8'h01, 0, 4'h0);
        idle(8'hFF, 1, 4'h0); idle(8'hFF, 0, 4'h0);
        idle(8'h00, 0, 4'h0); idle(8'h00, 1, 4'h0);
        run_trace("pc_wrap");

        // JZ at 0xFE with operand at 0xFF, not taken: PC wraps to 0x00
        clear_mem(); mem[0] = 8'h60; mem[1] = 8'hFE; mem[8'hFE] = 8'h70; mem[8'hFF] = 8'h12;
        start("opwrap");
        idle(8'h00, 1, 4'h0); idle(8'h00, 0, 4'h0);
        idle(8'h01, 1, 4'h0); idle(8'h01, 0, 4'h0);
        idle(8'hFE, 1, 4'h0); idle(8'hFE, 0, 4'h0);
        idle(8'hFF, 1, 4'h0); idle(8'hFF, 0, 4'h0);
        idle(8'h00, 1, 4'h0);
        run_trace("operand_wrap");

        // STA r7, reset asserted mid-EXEC
        clear_mem(); mem[0] = 8'h57; mem[1] = 8'hF0;
        start("sta");
        idle(8'h00, 1, 4'h0); idle(8'h00, 0, 4'h0);
        push_exp(8'h01, 0, 4'h0, 0, 0, 1, 0, 4'h7);
        run_trace("sta");
        async_reset_check("sta_async_reset");

        // Undefined opcode 1010 behaves as NOP
        clear_mem(); mem[0] = 8'hA3; mem[1] = 8'hF0;
        start("undef");
        idle(8'h00, 1, 4'h0); idle(8'h00, 0, 4'h0);
        idle(8'h01, 0, 4'h3); idle(8'h01, 1, 4'h3); idle(8'h01, 0, 4'h3);
        idle(8'h02, 0, 4'h0);
        push_exp(8'h02, 0, 4'h0, 0, 0, 0, 1, 4'h0);
        run_trace("undef_op");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
